// File: rtl/servo_pos_ramp_if.sv
// Target handshake between a position commander (master) and servo_pos_ramp (slave).
interface servo_pos_ramp_if;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [9:0] tgt;

    modport master (output tgt_valid, output tgt, input tgt_ready);
    modport slave  (input tgt_valid, input tgt, output tgt_ready);
endinterface

// File: rtl/servo_pos_ramp.sv
// Slew-rate-limited servo position source: clamps accepted targets and steps pos by at most
// STEP counts per PWM frame. Optional deadband filtering via `define SERVO_RAMP_DEADBAND_EN.
module servo_pos_ramp #(
    parameter int FRAME_BITS = 20,
    parameter int STEP       = 4,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 1023,
    parameter int POS_INIT   = 512,
    parameter int DEADBAND   = 2
) (
    input  logic                   clk,
    input  logic                   clr_n,
    servo_pos_ramp_if.slave        tgt_if,
    output logic [9:0]             pos,
    output logic                   frame,
    output logic                   moving,
    output logic                   at_target
);

    typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_MOVING} state_e;

    localparam logic [9:0]            MIN_C  = 10'(POS_MIN);
    localparam logic [9:0]            MAX_C  = 10'(POS_MAX);
    localparam logic [9:0]            INIT_C = 10'(POS_INIT);
    localparam logic signed [10:0]    STEP_S = 11'(STEP);
    localparam logic signed [10:0]    DB_S   = 11'(DEADBAND);
    localparam logic [FRAME_BITS-1:0] CNT_ONE = FRAME_BITS'(1);
`ifdef SERVO_RAMP_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   cnt_q;
    logic [9:0]              pos_q, pos_d;
    logic [9:0]              goal_q, goal_d;
    logic                    ready_q, ready_d;
    logic                    moving_q, moving_d;
    logic                    at_target_q, at_target_d;

    logic                    accept;
    logic [9:0]              tgt_clamped;
    logic signed [10:0]      diff, delta, goal_diff;
    logic                    in_band;

    assign frame            = &cnt_q;
    assign accept           = tgt_if.tgt_valid & ready_q;
    assign tgt_if.tgt_ready = ready_q;
    assign pos              = pos_q;
    assign moving           = moving_q;
    assign at_target        = at_target_q;

    // Datapath: the frame step always uses the goal held before this cycle's accept.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tgt_clamped = tgt_if.tgt;
        if (tgt_if.tgt < MIN_C)      tgt_clamped = MIN_C;
        else if (tgt_if.tgt > MAX_C) tgt_clamped = MAX_C;

        diff  = $signed({1'b0, goal_q}) - $signed({1'b0, pos_q});
        delta = diff;
        if (diff > STEP_S)       delta = STEP_S;
        else if (diff < -STEP_S) delta = -STEP_S;
        pos_d = frame ? pos_q + 10'(delta) : pos_q;

        goal_diff = $signed({1'b0, tgt_clamped}) - $signed({1'b0, goal_q});
        in_band   = DB_EN && (goal_diff <= DB_S) && (goal_diff >= -DB_S);
        goal_d    = (accept && !in_band) ? tgt_clamped : goal_q;
    end

    // Next state compares the stepped position against the possibly-new goal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STARTUP: if (frame) state_d = ST_IDLE;
            default:    state_d = (pos_d == goal_d) ? ST_IDLE : ST_MOVING;
        endcase
    end

    always_comb begin
        ready_d     = (state_d != ST_STARTUP);
        moving_d    = (state_d == ST_MOVING);
        at_target_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_STARTUP;
            cnt_q       <= '0;
            pos_q       <= INIT_C;
            goal_q      <= INIT_C;
            ready_q     <= 1'b0;
            moving_q    <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_q + CNT_ONE;
            pos_q       <= pos_d;
            goal_q      <= goal_d;
            ready_q     <= ready_d;
            moving_q    <= moving_d;
            at_target_q <= at_target_d;
        end
    end

endmodule

// File: tb/tb_servo_pos_ramp.sv
// Self-checking bench for servo_pos_ramp with 16-clock frames, POS_MIN=64, POS_MAX=900.
module tb_servo_pos_ramp;

    localparam int FB = 4, STP = 4, PMIN = 64, PMAX = 900, PINIT = 512, DB = 2;
`ifdef SERVO_RAMP_DEADBAND_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [9:0] pos;
    logic       frame, moving, at_target;
    int         n_checks = 0, n_errors = 0;

    servo_pos_ramp_if bus ();

    servo_pos_ramp #(.FRAME_BITS(FB), .STEP(STP), .POS_MIN(PMIN), .POS_MAX(PMAX),
                     .POS_INIT(PINIT), .DEADBAND(DB)) dut (
        .clk(clk), .clr_n(clr_n), .tgt_if(bus),
        .pos(pos), .frame(frame), .moving(moving), .at_target(at_target));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: phase 0 = waiting for first frame, 1 = holding, 2 = ramping.
    int m_cnt, m_pos, m_goal, m_phase;
    always @(posedge clk or negedge clr_n) begin : model_step
        int np, ng, c, d;
        bit fr, acc;
        if (!clr_n) begin
            m_cnt <= 0; m_pos <= PINIT; m_goal <= PINIT; m_phase <= 0;
        end else begin
            fr  = (m_cnt == (1 << FB) - 1);
            acc = bus.tgt_valid && (m_phase != 0);
            np  = m_pos;
            if (fr) begin
                d = m_goal - m_pos;
                if (d > STP) d = STP;
                if (d < -STP) d = -STP;
                np = m_pos + d;
            end
            ng = m_goal;
            if (acc) begin
                c = int'(bus.tgt);
                if (c < PMIN) c = PMIN;
                if (c > PMAX) c = PMAX;
                d = c - m_goal;
                if (!DB_ON || d > DB || d < -DB) ng = c;
            end
            if (m_phase == 0) m_phase <= fr ? 1 : 0;
            else              m_phase <= (np == ng) ? 1 : 2;
            m_pos  <= np;
            m_goal <= ng;
            m_cnt  <= (m_cnt + 1) % (1 << FB);
        end
    end

    task automatic accept(input int t);
        bus.tgt_valid = 1'b1;
        bus.tgt = 10'(t);
        @(negedge clk);
        bus.tgt_valid = 1'b0;
    endtask

    // Returns at the negedge following the next frame edge; ok = 0 on timeout.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (frame) begin
                @(negedge clk);
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        bus.tgt_valid = 1'b0;
        bus.tgt = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (pos !== 10'd512) begin n_errors++; $display("FAIL reset_pos: got %0d expected 512", pos); end
        n_checks++; if (bus.tgt_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", bus.tgt_ready); end
        n_checks++; if (moving !== 1'b0) begin n_errors++; $display("FAIL reset_moving: got %b expected 0", moving); end
        n_checks++; if (at_target !== 1'b0) begin n_errors++; $display("FAIL reset_at_target: got %b expected 0", at_target); end
        n_checks++; if (frame !== 1'b0) begin n_errors++; $display("FAIL reset_frame: got %b expected 0", frame); end
        clr_n = 1'b1;
    endtask

    task automatic test_startup;
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (frame) break;
        end
        // Frame is high during the 16th clock after release, i.e. after the 15th edge.
        n_checks++; if (n !== 15) begin n_errors++; $display("FAIL startup_frame_delay: got %0d edges expected 15", n); end
        n_checks++; if (bus.tgt_ready !== 1'b0) begin n_errors++; $display("FAIL startup_ready_early: got %b expected 0", bus.tgt_ready); end
        @(negedge clk);
        n_checks++; if (bus.tgt_ready !== 1'b1) begin n_errors++; $display("FAIL startup_ready: got %b expected 1", bus.tgt_ready); end
        n_checks++; if (at_target !== 1'b1) begin n_errors++; $display("FAIL startup_at_target: got %b expected 1", at_target); end
        n_checks++; if (pos !== 10'd512) begin n_errors++; $display("FAIL startup_pos: got %0d expected 512", pos); end
    endtask

    task automatic test_ramp;
        int exp_seq[5] = '{516, 520, 524, 528, 530};
        bit ok;
        accept(530);
        n_checks++; if (moving !== 1'b1) begin n_errors++; $display("FAIL ramp_moving_start: got %b expected 1", moving); end
        n_checks++; if (at_target !== 1'b0) begin n_errors++; $display("FAIL ramp_at_target_start: got %b expected 0", at_target); end
        for (int i = 0; i < 5; i++) begin
            wait_frame(ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL ramp_timeout: step %0d no frame", i); end
            n_checks++; if (int'(pos) !== exp_seq[i] || int'(pos) !== m_pos) begin
                n_errors++; $display("FAIL ramp_pos: step %0d got %0d expected %0d", i, pos, exp_seq[i]); end
            n_checks++; if (moving !== (i < 4)) begin n_errors++; $display("FAIL ramp_moving: step %0d got %b expected %b", i, moving, i < 4); end
        end
        n_checks++; if (at_target !== 1'b1) begin n_errors++; $display("FAIL ramp_at_target_end: got %b expected 1", at_target); end
    endtask

    task automatic test_deadband;
        bit ok;
        accept(531);
        n_checks++; if (moving !== !DB_ON) begin n_errors++; $display("FAIL deadband_moving: got %b expected %b", moving, !DB_ON); end
        wait_frame(ok);
        n_checks++; if (!ok || int'(pos) !== (DB_ON ? 530 : 531)) begin
            n_errors++; $display("FAIL deadband_pos: got %0d expected %0d", pos, DB_ON ? 530 : 531); end
        n_checks++; if (moving !== 1'b0 || at_target !== 1'b1) begin
            n_errors++; $display("FAIL deadband_idle: got moving=%b at_target=%b expected 0/1", moving, at_target); end
    endtask

    task automatic test_reset_mid_ramp;
        bit ok;
        accept(600);
        for (int i = 0; i < 40; i++) begin
            wait_frame(ok);
            if (!ok || pos >= 10'd540) break;
        end
        n_checks++; if (int'(pos) !== m_pos || pos < 10'd540) begin
            n_errors++; $display("FAIL midreset_pre_pos: got %0d expected %0d (>=540)", pos, m_pos); end
        #2 clr_n = 1'b0;
        #1;
        n_checks++; if (pos !== 10'd512) begin n_errors++; $display("FAIL midreset_pos: got %0d expected 512", pos); end
        n_checks++; if (moving !== 1'b0 || at_target !== 1'b0 || bus.tgt_ready !== 1'b0) begin
            n_errors++; $display("FAIL midreset_flags: got moving=%b at_target=%b ready=%b expected 0/0/0", moving, at_target, bus.tgt_ready); end
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.tgt_ready !== 1'b0) begin n_errors++; $display("FAIL midreset_startup_ready: got %b expected 0", bus.tgt_ready); end
        wait_frame(ok);
        n_checks++; if (!ok || bus.tgt_ready !== 1'b1 || pos !== 10'd512) begin
            n_errors++; $display("FAIL midreset_restart: got ready=%b pos=%0d expected 1/512", bus.tgt_ready, pos); end
    endtask

    task automatic test_reversal;
        bit ok;
        bit found = 1'b0;
        accept(600);
        for (int i = 0; i < 200; i++) begin
            if (frame && pos == 10'd520) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL reversal_timeout: got pos=%0d expected frame at 520", pos); end
        accept(500);
        n_checks++; if (pos !== 10'd524 || moving !== 1'b1) begin
            n_errors++; $display("FAIL reversal_first: got pos=%0d moving=%b expected 524/1", pos, moving); end
        for (int v = 520; v >= 500; v -= 4) begin
            wait_frame(ok);
            n_checks++; if (!ok || int'(pos) !== v) begin n_errors++; $display("FAIL reversal_pos: got %0d expected %0d", pos, v); end
        end
        n_checks++; if (at_target !== 1'b1 || moving !== 1'b0) begin
            n_errors++; $display("FAIL reversal_idle: got at_target=%b moving=%b expected 1/0", at_target, moving); end
    endtask

    task automatic test_clamp(input int t, input int limit);
        bit ok;
        accept(t);
        for (int i = 0; i < 260; i++) begin
            wait_frame(ok);
            n_checks++; if (!ok || int'(pos) > PMAX || int'(pos) < PMIN) begin
                n_errors++; $display("FAIL clamp_range: got %0d expected within [%0d,%0d]", pos, PMIN, PMAX); break; end
            if (at_target) break;
        end
        n_checks++; if (int'(pos) !== limit || at_target !== 1'b1) begin
            n_errors++; $display("FAIL clamp_final: got pos=%0d at_target=%b expected %0d/1", pos, at_target, limit); end
    endtask

    task automatic test_random;
        int t, shown = 0;
        for (int i = 0; i < 3000; i++) begin
            n_checks++;
            if (int'(pos) !== m_pos || frame !== (m_cnt == (1 << FB) - 1) ||
                bus.tgt_ready !== (m_phase != 0) || moving !== (m_phase == 2) || at_target !== (m_phase == 1)) begin
                n_errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle %0d: got pos=%0d frame=%b ready=%b moving=%b at_target=%b expected pos=%0d phase=%0d cnt=%0d",
                             i, pos, frame, bus.tgt_ready, moving, at_target, m_pos, m_phase, m_cnt);
                end
            end
            if ($urandom_range(0, 2) == 0) t = int'(pos) + $urandom_range(0, 8) - 4;
            else                           t = $urandom_range(0, 1023);
            if (t < 0) t = 0;
            if (t > 1023) t = 1023;
            bus.tgt_valid = ($urandom_range(0, 5) == 0);
            bus.tgt = 10'(t);
            @(negedge clk);
        end
        bus.tgt_valid = 1'b0;
    endtask

    initial begin
        bus.tgt_valid = 1'b0;
        bus.tgt = '0;
        @(negedge clk);
        test_reset;
        test_startup;
        test_ramp;
        test_deadband;
        test_reset_mid_ramp;
        test_reversal;
        test_clamp(1000, PMAX);
        test_clamp(10, PMIN);
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
